cpu_debug_cmd_bridge: RTL and testbench

Parametrised system-clock half of the CPU JTAG debug slave. It synchronises the virtual-JTAG update strobes from the TCK domain and captures the shift register and IR on each update-DR. Captured commands are buffered in a small FIFO, so back-to-back JTAG scans are not lost while the CPU side is busy. Each command is presented through a valid/ready handshake and produces a one-hot per-IR action strobe when it is consumed. It sits between the TCK-domain scan logic and the OCI break/ocimem/trace-control blocks.

---
 rtl/cpu_debug_cmd_bridge.sv | 139 +++++++++++++
 tb/tb_cpu_debug_cmd_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_cmd_bridge.sv
// System-clock half of the CPU JTAG debug slave: synchronises update strobes from
// the TCK domain, buffers captured scans in a show-ahead FIFO and issues per-IR action strobes.
module cpu_debug_cmd_bridge #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             sr,
  input  logic [IR_W-1:0]               ir_in,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          clear_ovf,
  output logic [DATA_W-1:0]             jdo,
  output logic [IR_W-1:0]               cmd_ir,
  output logic                          cmd_valid,
  output logic [(1<<IR_W)-1:0]          act_strobe,
  output logic                          ir_update,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_prev;
  logic                   r_uir_prev;
  logic                   w_udr_rise;
  logic                   w_uir_rise;

  logic [DATA_W-1:0]      r_mem_data [FIFO_DEPTH];
  logic [IR_W-1:0]        r_mem_ir   [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [LVL_W-1:0]       r_level;
  logic [DATA_W-1:0]      r_last_data;
  logic [IR_W-1:0]        r_last_ir;
  logic                   r_ir_update;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_drop_count;

  logic                   w_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_udr_prev  <= 1'b0;
      r_uir_prev  <= 1'b0;
      r_ir_update <= 1'b0;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev  <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev  <= r_uir_sync[SYNC_STAGES-1];
      r_ir_update <= w_uir_rise;
    end
  end

  assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
  assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_valid & cmd_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push  = w_udr_rise & (~w_full | w_pop);
  assign w_drop  = w_udr_rise & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_ir[i]   <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_last_data <= '0;
      r_last_ir   <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= sr;
        r_mem_ir[r_wptr]   <= ir_in;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_last_data <= r_mem_data[r_rptr];
        r_last_ir   <= r_mem_ir[r_rptr];
        r_rptr      <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= clear_ovf ? CNT_W'(1)
                    : ((r_drop_count == '1) ? r_drop_count : r_drop_count + CNT_W'(1));
    end else if (clear_ovf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  // Empty FIFO keeps presenting the last consumed command rather than stale storage.
  assign jdo        = w_valid ? r_mem_data[r_rptr] : r_last_data;
  assign cmd_ir     = w_valid ? r_mem_ir[r_rptr]   : r_last_ir;
  assign cmd_valid  = w_valid;
  assign ir_update  = r_ir_update;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  always_comb begin
    act_strobe = '0;
    if (w_pop) act_strobe[cmd_ir] = 1'b1;
  end

endmodule

// File: tb/tb_cpu_debug_cmd_bridge.sv
// Scoreboard bench for cpu_debug_cmd_bridge: stimulus queues expected commands,
// a negedge monitor checks every consumed command and its action strobe.
module tb_cpu_debug_cmd_bridge;
  localparam int DW = 38;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] sr = '0;
  logic [IW-1:0] ir_in = '0;
  logic          vs_udr = 1'b0;
  logic          vs_uir = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [DW-1:0] jdo;
  logic [IW-1:0] cmd_ir;
  logic          cmd_valid;
  logic [3:0]    act_strobe;
  logic          ir_update;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic [7:0]    drop_count;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] ir;
  } cmd_t;

  cmd_t sb[$];
  cmd_t mon_e;
  cmd_t tmp_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DW-1:0] last_d;

  cpu_debug_cmd_bridge #(
    .DATA_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr),
    .vs_uir(vs_uir), .cmd_ready(cmd_ready), .clear_ovf(clear_ovf), .jdo(jdo),
    .cmd_ir(cmd_ir), .cmd_valid(cmd_valid), .act_strobe(act_strobe),
    .ir_update(ir_update), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [DW-1:0] d, input logic [IW-1:0] ir, input bit accept);
    sr = d;
    ir_in = ir;
    vs_udr = 1'b1;
    if (accept) begin
      tmp_e = {d, ir};
      sb.push_back(tmp_e);
    end
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic drain(input int n);
    cmd_ready = 1'b1;
    tick(n);
    cmd_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got jdo %0h ir %0h, expected no pop", jdo, cmd_ir);
        end else begin
          mon_e = sb.pop_front();
          check("pop_jdo", 64'(jdo), 64'(mon_e.d));
          check("pop_ir", 64'(cmd_ir), 64'(mon_e.ir));
          check("pop_strobe", 64'(act_strobe), 64'(1) << mon_e.ir);
        end
      end else begin
        check("idle_strobe", 64'(act_strobe), 64'(0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_valid", 64'(cmd_valid), 64'(0));
    check("rst_jdo", 64'(jdo), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Single scan with latency check
    sr = 38'h2A_DEAD_BEEF;
    ir_in = 2'b01;
    vs_udr = 1'b1;
    tmp_e = {38'h2A_DEAD_BEEF, 2'b01};
    sb.push_back(tmp_e);
    tick(2);
    check("lat_early_valid", 64'(cmd_valid), 64'(0));
    tick(1);
    check("lat_valid", 64'(cmd_valid), 64'(1));
    check("single_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
    check("single_ir", 64'(cmd_ir), 64'(1));
    check("single_level", 64'(fifo_level), 64'(1));
    tick(3);
    vs_udr = 1'b0;
    tick(4);
    check("single_hold_level", 64'(fifo_level), 64'(1));
    drain(1);
    check("single_after_valid", 64'(cmd_valid), 64'(0));

    // Burst of 6 with no consumer: two dropped
    for (int i = 0; i < 6; i++) begin
      scan(38'h10_0000_0000 + 38'(i), 2'(i % 4), i < 4);
      if (i == 3) last_d = 38'h10_0000_0000 + 38'(i);
    end
    check("burst_level", 64'(fifo_level), 64'(4));
    check("burst_ovf", 64'(overflow), 64'(1));
    check("burst_drop", 64'(drop_count), 64'(2));
    drain(5);
    check("burst_empty", 64'(cmd_valid), 64'(0));
    check("burst_level0", 64'(fifo_level), 64'(0));
    check("empty_hold_jdo", 64'(jdo), 64'(last_d));
    check("empty_hold_ir", 64'(cmd_ir), 64'(3));
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("clr_ovf", 64'(overflow), 64'(0));
    check("clr_drop", 64'(drop_count), 64'(0));

    // Full FIFO with pop in the exact push cycle
    for (int i = 0; i < 4; i++) scan(38'h20_0000_0000 + 38'(i), 2'(i), 1'b1);
    sr = 38'h3F_1234_5678;
    ir_in = 2'b10;
    vs_udr = 1'b1;
    tmp_e = {38'h3F_1234_5678, 2'b10};
    sb.push_back(tmp_e);
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("full_pp_level", 64'(fifo_level), 64'(4));
    check("full_pp_ovf", 64'(overflow), 64'(0));
    check("full_pp_drop", 64'(drop_count), 64'(0));
    tick(2);
    vs_udr = 1'b0;
    tick(4);
    drain(5);
    check("full_pp_drained", 64'(fifo_level), 64'(0));

    // Saturating drop counter
    for (int i = 0; i < 4; i++) scan(38'h30_0000_0000 + 38'(i), 2'(3 - i), 1'b1);
    for (int i = 0; i < 300; i++) scan(38'h0F_0000_0000 + 38'(i), 2'(i % 4), 1'b0);
    check("sat_drop", 64'(drop_count), 64'(255));
    check("sat_ovf", 64'(overflow), 64'(1));
    check("sat_level", 64'(fifo_level), 64'(4));
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("clr2_ovf", 64'(overflow), 64'(0));
    check("clr2_drop", 64'(drop_count), 64'(0));
    sr = 38'h01_1111_1111;
    ir_in = 2'b00;
    vs_udr = 1'b1;
    tick(2);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("clr_vs_drop_ovf", 64'(overflow), 64'(1));
    check("clr_vs_drop_cnt", 64'(drop_count), 64'(1));
    tick(2);
    vs_udr = 1'b0;
    tick(4);
    drain(5);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;

    // IR update pulse, alone and together with a DR update
    vs_uir = 1'b1;
    tick(2);
    check("uir_early", 64'(ir_update), 64'(0));
    tick(1);
    check("uir_pulse", 64'(ir_update), 64'(1));
    tick(1);
    check("uir_end", 64'(ir_update), 64'(0));
    check("uir_level", 64'(fifo_level), 64'(0));
    tick(1);
    vs_uir = 1'b0;
    tick(4);
    sr = 38'h15_5555_AAAA;
    ir_in = 2'b11;
    vs_udr = 1'b1;
    vs_uir = 1'b1;
    tmp_e = {38'h15_5555_AAAA, 2'b11};
    sb.push_back(tmp_e);
    tick(3);
    check("both_uir", 64'(ir_update), 64'(1));
    check("both_valid", 64'(cmd_valid), 64'(1));
    check("both_level", 64'(fifo_level), 64'(1));
    tick(1);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    tick(4);

    // Asynchronous reset with 3 entries queued
    scan(38'h22_2222_2222, 2'b01, 1'b1);
    scan(38'h33_3333_3333, 2'b10, 1'b1);
    check("pre_rst_level", 64'(fifo_level), 64'(3));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("arst_valid", 64'(cmd_valid), 64'(0));
    check("arst_jdo", 64'(jdo), 64'(0));
    check("arst_ir", 64'(cmd_ir), 64'(0));
    check("arst_strobe", 64'(act_strobe), 64'(0));
    check("arst_uir", 64'(ir_update), 64'(0));
    check("arst_level", 64'(fifo_level), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    check("arst_drop", 64'(drop_count), 64'(0));
    tick(2);
    reset_n = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(3);
    check("post_rst_valid", 64'(cmd_valid), 64'(0));
    check("post_rst_strobe", 64'(act_strobe), 64'(0));
    cmd_ready = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
